// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - host-side PS/2 device->host frame receiver
// Synchronises and glitch-filters ps2clk/ps2data, deserialises 11-bit frames, flags errors.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic          clk_f_q, clk_f_d, data_f_q, data_f_d, clk_f_prev_q, clk_f_prev_d;
  logic [FW-1:0] clk_fcnt_q, clk_fcnt_d, data_fcnt_q, data_fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic          par_bit_q, par_bit_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d, busy_q, busy_d;
  logic          fall, par_ok;

  // Input path: 2-FF synchroniser, then a level is accepted only after
  // FILTER_LEN consecutive samples disagree with the current filtered level.
  always_comb begin
    clk_sync_d   = {clk_sync_q[0], ps2clk};
    data_sync_d  = {data_sync_q[0], ps2data};
    clk_f_d      = clk_f_q;
    clk_fcnt_d   = '0;
    data_f_d     = data_f_q;
    data_fcnt_d  = '0;
    if (clk_sync_q[1] != clk_f_q) begin
      if (clk_fcnt_q == FW'(FILTER_LEN - 1)) clk_f_d = clk_sync_q[1];
      else clk_fcnt_d = clk_fcnt_q + FW'(1);
    end
    if (data_sync_q[1] != data_f_q) begin
      if (data_fcnt_q == FW'(FILTER_LEN - 1)) data_f_d = data_sync_q[1];
      else data_fcnt_d = data_fcnt_q + FW'(1);
    end
    clk_f_prev_d = clk_f_q;
  end

  assign fall   = clk_f_prev_q & ~clk_f_q;
  assign par_ok = (^shreg_q) ^ par_bit_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_bit_d    = par_bit_q;
    to_cnt_d     = to_cnt_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (!rx_en) begin
      state_d  = IDLE;
      to_cnt_d = '0;
    end else if (state_q == IDLE) begin
      to_cnt_d = '0;
      if (fall && !data_f_q) begin
        state_d   = DATA;
        bit_cnt_d = 3'd0;
      end
    end else if (fall) begin
      // A fall always beats a simultaneous timeout.
      to_cnt_d = '0;
      case (state_q)
        DATA: begin
          shreg_d   = {data_f_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_bit_d = data_f_q;
          state_d   = STOP;
        end
        default: begin
          rx_data_d    = shreg_q;
          rx_valid_d   = data_f_q & par_ok;
          parity_err_d = ~par_ok;
          frame_err_d  = ~data_f_q;
          state_d      = IDLE;
        end
      endcase
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      to_cnt_d    = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      clk_f_q      <= 1'b1;
      data_f_q     <= 1'b1;
      clk_f_prev_q <= 1'b1;
      clk_fcnt_q   <= '0;
      data_fcnt_q  <= '0;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      par_bit_q    <= 1'b0;
      to_cnt_q     <= '0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_f_q      <= clk_f_d;
      data_f_q     <= data_f_d;
      clk_f_prev_q <= clk_f_prev_d;
      clk_fcnt_q   <= clk_fcnt_d;
      data_fcnt_q  <= data_fcnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_bit_q    <= par_bit_d;
      to_cnt_q     <= to_cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
